conv33_mac_pe: RTL

- Downstream stage of the 3x3 weight loader. Consumes its nine parallel weights and its weight-valid pulse.
- Each cycle, multiplies a 3x3 pixel window by the held weights and reduces the nine products through a registered adder tree.
- Accumulates window sums across input channels and emits one result per output pixel.
- Sits between the weight loader / line-buffer window generator and the activation/requantise stage.

---
 rtl/conv33_mac_pe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/conv33_mac_pe.sv
// conv33_mac_pe: 3x3 multiply-accumulate processing element.
// Holds nine kernel weights and multiplies each incoming 3x3 pixel window
// by them. The products are reduced through a registered adder tree
// (products -> row sums -> window sum), and window sums are accumulated
// across input channels. One result is emitted per output pixel.
module conv33_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] weight_0,
  input  logic [DATA_WIDTH-1:0] weight_1,
  input  logic [DATA_WIDTH-1:0] weight_2,
  input  logic [DATA_WIDTH-1:0] weight_3,
  input  logic [DATA_WIDTH-1:0] weight_4,
  input  logic [DATA_WIDTH-1:0] weight_5,
  input  logic [DATA_WIDTH-1:0] weight_6,
  input  logic [DATA_WIDTH-1:0] weight_7,
  input  logic [DATA_WIDTH-1:0] weight_8,
  input  logic                  weight_valid,
  input  logic [DATA_WIDTH-1:0] pix_0,
  input  logic [DATA_WIDTH-1:0] pix_1,
  input  logic [DATA_WIDTH-1:0] pix_2,
  input  logic [DATA_WIDTH-1:0] pix_3,
  input  logic [DATA_WIDTH-1:0] pix_4,
  input  logic [DATA_WIDTH-1:0] pix_5,
  input  logic [DATA_WIDTH-1:0] pix_6,
  input  logic [DATA_WIDTH-1:0] pix_7,
  input  logic [DATA_WIDTH-1:0] pix_8,
  input  logic                  pix_valid,
  input  logic                  ch_first,
  input  logic                  ch_last,
  output logic                  weight_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  out_valid,
  output logic                  drop_err
);

  localparam int PW = 2 * DATA_WIDTH;  // product width
  localparam int RW = PW + 2;          // row-sum width (sum of three products)

  // Sign-extend a product to row-sum width.
  function automatic logic [RW-1:0] ext_prod(input logic [PW-1:0] v);
    return {{2{v[PW-1]}}, v};
  endfunction

  // Sign-extend a row sum to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] ext_row(input logic [RW-1:0] v);
    return {{(ACC_WIDTH-RW){v[RW-1]}}, v};
  endfunction

  logic [DATA_WIDTH-1:0] w_in_s   [9];
  logic [DATA_WIDTH-1:0] pix_in_s [9];
  logic [DATA_WIDTH-1:0] w_r      [9];
  logic                  weight_ready_r;
  logic                  drop_err_r;
  logic                  accept_s;

  logic [PW-1:0]         prod_s [9];
  logic [PW-1:0]         p1_r   [9];
  logic                  v1_r, f1_r, l1_r;

  logic [RW-1:0]         row_s  [3];
  logic [RW-1:0]         row_r  [3];
  logic                  v2_r, f2_r, l2_r;

  logic [ACC_WIDTH-1:0]  wsum_s;
  logic [ACC_WIDTH-1:0]  wsum_r;
  logic                  v3_r, f3_r, l3_r;

  logic [ACC_WIDTH-1:0]  acc_next_s;
  logic [ACC_WIDTH-1:0]  acc_r;
  logic [ACC_WIDTH-1:0]  result_r;
  logic                  out_valid_r;

  assign w_in_s   = '{weight_0, weight_1, weight_2, weight_3, weight_4,
                      weight_5, weight_6, weight_7, weight_8};
  assign pix_in_s = '{pix_0, pix_1, pix_2, pix_3, pix_4,
                      pix_5, pix_6, pix_7, pix_8};

  // A window is only accepted once a weight set has been held; this uses the
  // registered ready flag, so a same-cycle first weight load still drops it.
  assign accept_s = pix_valid & weight_ready_r;

  assign weight_ready = weight_ready_r;
  assign drop_err     = drop_err_r;
  assign result       = result_r;
  assign out_valid    = out_valid_r;

  // Capture the kernel weights on each weight_valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) w_r[k] <= {DATA_WIDTH{1'b0}};
      weight_ready_r <= 1'b0;
    end else if (weight_valid) begin
      for (int k = 0; k < 9; k++) w_r[k] <= w_in_s[k];
      weight_ready_r <= 1'b1;
    end
  end

  // Sticky flag for windows that arrived before any weights were held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err_r <= 1'b0;
    end else if (pix_valid && !weight_ready_r) begin
      drop_err_r <= 1'b1;
    end
  end

  // Signed products. The low PW bits of the sign-extended product are exact.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_s[k] = {{DATA_WIDTH{pix_in_s[k][DATA_WIDTH-1]}}, pix_in_s[k]} *
                  {{DATA_WIDTH{w_r[k][DATA_WIDTH-1]}}, w_r[k]};
    end
  end

  // Stage S1: register the products together with the window tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r <= 1'b0;
      f1_r <= 1'b0;
      l1_r <= 1'b0;
      for (int k = 0; k < 9; k++) p1_r[k] <= {PW{1'b0}};
    end else begin
      v1_r <= accept_s;
      f1_r <= ch_first;
      l1_r <= ch_last;
      for (int k = 0; k < 9; k++) p1_r[k] <= prod_s[k];
    end
  end

  // Row sums of three sign-extended products each.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_s[r] = ext_prod(p1_r[3*r]) + ext_prod(p1_r[3*r+1]) + ext_prod(p1_r[3*r+2]);
    end
  end

  // Stage S2: register the row sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r <= 1'b0;
      f2_r <= 1'b0;
      l2_r <= 1'b0;
      for (int r = 0; r < 3; r++) row_r[r] <= {RW{1'b0}};
    end else begin
      v2_r <= v1_r;
      f2_r <= f1_r;
      l2_r <= l1_r;
      for (int r = 0; r < 3; r++) row_r[r] <= row_s[r];
    end
  end

  // Window sum at accumulator width.
  always_comb begin
    wsum_s = ext_row(row_r[0]) + ext_row(row_r[1]) + ext_row(row_r[2]);
  end

  // Stage S3: register the window sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3_r   <= 1'b0;
      f3_r   <= 1'b0;
      l3_r   <= 1'b0;
      wsum_r <= {ACC_WIDTH{1'b0}};
    end else begin
      v3_r   <= v2_r;
      f3_r   <= f2_r;
      l3_r   <= l2_r;
      wsum_r <= wsum_s;
    end
  end

  // First channel restarts the accumulation; otherwise add (wraps modulo 2^ACC_WIDTH).
  always_comb begin
    if (f3_r) begin
      acc_next_s = wsum_r;
    end else begin
      acc_next_s = acc_r + wsum_r;
    end
  end

  // Stage S4: accumulate valid windows and publish on the last channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r       <= {ACC_WIDTH{1'b0}};
      result_r    <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= v3_r & l3_r;
      if (v3_r) begin
        acc_r <= acc_next_s;
        if (l3_r) result_r <= acc_next_s;
      end
    end
  end

endmodule
